// File: rtl/hazard_pkg.sv
// Shared types and defaults for the ID-stage hazard/stall controller.
package hazard_pkg;

  typedef enum logic [2:0] {
    CauseNone    = 3'd0,
    CauseLoadUse = 3'd1,
    CauseRawLl   = 3'd2,
    CauseWawLl   = 3'd3,
    CauseStruct  = 3'd4
  } hazard_cause_e;

  localparam int unsigned UnitDiv = 0;
  localparam int unsigned UnitMul = 1;

  localparam int unsigned DefNumRegs    = 32;
  localparam int unsigned DefRegAw      = 5;
  localparam int unsigned DefNumLlUnits = 2;
  localparam int unsigned DefUnitW      = 1;
  localparam int unsigned DefCntW       = 32;

endpackage

// File: rtl/hazard_sb_bank.sv
// Per-register pending bits and per-unit busy bits for long-latency operations.
module hazard_sb_bank
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_REGS     = DefNumRegs,
  parameter int unsigned REG_AW       = DefRegAw,
  parameter int unsigned NUM_LL_UNITS = DefNumLlUnits,
  parameter int unsigned UNIT_W       = DefUnitW
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           issue,
  input  logic [REG_AW-1:0]              issue_rd,
  input  logic                           issue_rd_we,
  input  logic [UNIT_W-1:0]              issue_unit,
  input  logic [NUM_LL_UNITS-1:0]        ll_done,
  input  logic [NUM_LL_UNITS*REG_AW-1:0] ll_done_rd,
  output logic [NUM_REGS-1:0]            sb_pending,
  output logic [NUM_LL_UNITS-1:0]        unit_busy
);

  logic [NUM_REGS-1:0]     pending_d, pending_q;
  logic [NUM_LL_UNITS-1:0] busy_d, busy_q;

  // Clears are applied first so a same-cycle set on the same bit wins.
  always_comb begin
    pending_d = pending_q;
    busy_d    = busy_q;
    for (int u = 0; u < NUM_LL_UNITS; u++) begin
      if (ll_done[u]) begin
        busy_d[u] = 1'b0;
        pending_d[ll_done_rd[u*REG_AW +: REG_AW]] = 1'b0;
      end
    end
    if (issue) begin
      busy_d[issue_unit] = 1'b1;
      if (issue_rd_we && (issue_rd != '0)) begin
        pending_d[issue_rd] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      busy_q    <= '0;
    end else begin
      pending_q <= pending_d;
      busy_q    <= busy_d;
    end
  end

  assign sb_pending = pending_q;
  assign unit_busy  = busy_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage stall controller: load-use, RAW/WAW against long-latency results, unit conflicts.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_REGS     = DefNumRegs,
  parameter int unsigned REG_AW       = DefRegAw,
  parameter int unsigned NUM_LL_UNITS = DefNumLlUnits,
  parameter int unsigned UNIT_W       = DefUnitW,
  parameter int unsigned CNT_W        = DefCntW
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           ifid_valid,
  input  logic [REG_AW-1:0]              ifid_rs1,
  input  logic [REG_AW-1:0]              ifid_rs2,
  input  logic                           ifid_rs1_used,
  input  logic                           ifid_rs2_used,
  input  logic [REG_AW-1:0]              ifid_rd,
  input  logic                           ifid_rd_we,
  input  logic                           ifid_ll_issue,
  input  logic [UNIT_W-1:0]              ifid_ll_unit,
  input  logic [REG_AW-1:0]              idex_rd,
  input  logic                           idex_mem_read,
  input  logic [NUM_LL_UNITS-1:0]        ll_done,
  input  logic [NUM_LL_UNITS*REG_AW-1:0] ll_done_rd,
  output logic                           pc_write,
  output logic                           ifid_write,
  output logic                           idex_write,
  output logic                           control_mux_sel,
  output logic [2:0]                     hazard_cause,
  output logic [NUM_REGS-1:0]            sb_pending,
  output logic [CNT_W-1:0]               stall_count
);

  logic [NUM_LL_UNITS-1:0] unit_busy;
  logic [NUM_REGS-1:0]     done_mask, pend_vec;
  logic [NUM_LL_UNITS-1:0] busy_vec;
  logic                    act, src1_ok, src2_ok;
  logic                    load_use, raw_ll, waw_ll, struct_hz;
  logic                    stall, issue;
  hazard_cause_e           cause;
  logic [CNT_W-1:0]        stall_count_d, stall_count_q;

  hazard_sb_bank #(
    .NUM_REGS    (NUM_REGS),
    .REG_AW      (REG_AW),
    .NUM_LL_UNITS(NUM_LL_UNITS),
    .UNIT_W      (UNIT_W)
  ) u_sb_bank (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue      (issue),
    .issue_rd   (ifid_rd),
    .issue_rd_we(ifid_rd_we),
    .issue_unit (ifid_ll_unit),
    .ll_done    (ll_done),
    .ll_done_rd (ll_done_rd),
    .sb_pending (sb_pending),
    .unit_busy  (unit_busy)
  );

  // Completing results are bypassed through the write-first regfile, so they no longer block.
  always_comb begin
    done_mask = '0;
    for (int u = 0; u < NUM_LL_UNITS; u++) begin
      if (ll_done[u]) begin
        done_mask[ll_done_rd[u*REG_AW +: REG_AW]] = 1'b1;
      end
    end
  end

  assign pend_vec = sb_pending & ~done_mask;
  assign busy_vec = unit_busy & ~ll_done;

  assign act     = ifid_valid & ~flush;
  assign src1_ok = ifid_rs1_used & (ifid_rs1 != '0);
  assign src2_ok = ifid_rs2_used & (ifid_rs2 != '0);

  assign load_use = act & idex_mem_read & (idex_rd != '0) &
                    ((src1_ok & (ifid_rs1 == idex_rd)) | (src2_ok & (ifid_rs2 == idex_rd)));
  assign raw_ll   = act & ((src1_ok & pend_vec[ifid_rs1]) | (src2_ok & pend_vec[ifid_rs2]));
  assign waw_ll   = act & ifid_rd_we & (ifid_rd != '0) & pend_vec[ifid_rd];
  assign struct_hz = act & ifid_ll_issue & busy_vec[ifid_ll_unit];

  always_comb begin
    cause = CauseNone;
    if (load_use) begin
      cause = CauseLoadUse;
    end else if (raw_ll) begin
      cause = CauseRawLl;
    end else if (waw_ll) begin
      cause = CauseWawLl;
    end else if (struct_hz) begin
      cause = CauseStruct;
    end
  end

  assign stall           = (cause != CauseNone);
  assign issue           = act & ifid_ll_issue & ~stall;
  assign pc_write        = ~stall;
  assign ifid_write      = ~stall;
  assign idex_write      = 1'b1;
  assign control_mux_sel = stall;
  assign hazard_cause    = cause;

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: vector table plus multi-cycle sequences.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam int unsigned CntW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, ifid_valid;
  logic [4:0]  ifid_rs1, ifid_rs2, ifid_rd, idex_rd;
  logic        ifid_rs1_used, ifid_rs2_used, ifid_rd_we, ifid_ll_issue;
  logic [0:0]  ifid_ll_unit;
  logic        idex_mem_read;
  logic [1:0]  ll_done;
  logic [9:0]  ll_done_rd;
  logic        pc_write, ifid_write, idex_write, control_mux_sel;
  logic [2:0]  hazard_cause;
  logic [31:0] sb_pending;
  logic [CntW-1:0] stall_count;

  hazard_scoreboard #(
    .NUM_REGS    (32),
    .REG_AW      (5),
    .NUM_LL_UNITS(2),
    .UNIT_W      (1),
    .CNT_W       (CntW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .ifid_valid     (ifid_valid),
    .ifid_rs1       (ifid_rs1),
    .ifid_rs2       (ifid_rs2),
    .ifid_rs1_used  (ifid_rs1_used),
    .ifid_rs2_used  (ifid_rs2_used),
    .ifid_rd        (ifid_rd),
    .ifid_rd_we     (ifid_rd_we),
    .ifid_ll_issue  (ifid_ll_issue),
    .ifid_ll_unit   (ifid_ll_unit),
    .idex_rd        (idex_rd),
    .idex_mem_read  (idex_mem_read),
    .ll_done        (ll_done),
    .ll_done_rd     (ll_done_rd),
    .pc_write       (pc_write),
    .ifid_write     (ifid_write),
    .idex_write     (idex_write),
    .control_mux_sel(control_mux_sel),
    .hazard_cause   (hazard_cause),
    .sb_pending     (sb_pending),
    .stall_count    (stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic       flush;
    logic [4:0] rs1;
    logic       rs1_used;
    logic [4:0] rs2;
    logic       rs2_used;
    logic [4:0] idex_rd;
    logic       mem_read;
    logic [2:0] cause;
  } vec_t;

  int         errors = 0;
  int         checks = 0;
  int         exp_stall = 0;
  logic [6:0] exp_q[$];
  vec_t       vecs[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // {pc_write, ifid_write, idex_write, control_mux_sel, hazard_cause}
  function automatic logic [6:0] exp_outs(input logic [2:0] c);
    return (c == 3'd0) ? {4'b1110, c} : {4'b0011, c};
  endfunction

  task automatic idle();
    flush = 0; ifid_valid = 0; ifid_rs1 = 0; ifid_rs2 = 0; ifid_rs1_used = 0;
    ifid_rs2_used = 0; ifid_rd = 0; ifid_rd_we = 0; ifid_ll_issue = 0; ifid_ll_unit = 0;
    idex_rd = 0; idex_mem_read = 0; ll_done = 0; ll_done_rd = 0;
  endtask

  task automatic ll_op(input int unsigned unit, input logic [4:0] rd);
    ifid_valid = 1; ifid_ll_issue = 1; ifid_ll_unit = 1'(unit); ifid_rd = rd; ifid_rd_we = 1;
  endtask

  // One ID cycle: expectation queued at drive time, popped when outputs are sampled.
  task automatic cycle(input string name, input logic [2:0] c);
    logic [6:0] e;
    exp_q.push_back(exp_outs(c));
    #1;
    e = exp_q.pop_front();
    check(name, {25'd0, pc_write, ifid_write, idex_write, control_mux_sel, hazard_cause},
          {25'd0, e});
    if (c != 3'd0 && exp_stall < 15) exp_stall++;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0};
    vecs[1] = '{1'b1, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 3'd1};
    vecs[2] = '{1'b1, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b1, 3'd0};
    vecs[3] = '{1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 3'd0};
    vecs[4] = '{1'b1, 1'b0, 5'd5, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 3'd0};
    vecs[5] = '{1'b1, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b0, 3'd0};
    vecs[6] = '{1'b1, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 3'd0};
    vecs[7] = '{1'b1, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 3'd1};
    vecs[8] = '{1'b0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 3'd0};
    vecs[9] = '{1'b1, 1'b0, 5'd3, 1'b1, 5'd5, 1'b1, 5'd4, 1'b1, 3'd0};

    idle();
    rst_n = 0;
    #1;
    check("reset_pending", sb_pending, 32'd0);
    check("reset_stall_count", {28'd0, stall_count}, 32'd0);
    check("reset_outputs", {25'd0, pc_write, ifid_write, idex_write, control_mux_sel,
          hazard_cause}, {25'd0, exp_outs(3'd0)});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 10; i++) begin
      idle();
      flush = vecs[i].flush; ifid_valid = vecs[i].valid;
      ifid_rs1 = vecs[i].rs1; ifid_rs1_used = vecs[i].rs1_used;
      ifid_rs2 = vecs[i].rs2; ifid_rs2_used = vecs[i].rs2_used;
      idex_rd = vecs[i].idex_rd; idex_mem_read = vecs[i].mem_read;
      cycle($sformatf("vec%0d", i), vecs[i].cause);
    end
    check("stall_count_table", {28'd0, stall_count}, exp_stall);

    // RAW / WAW / structural against an in-flight divide
    idle(); ll_op(UnitDiv, 5'd7);
    cycle("div_issue", 3'd0);
    check("pend_after_div", sb_pending, 32'h80);
    idle(); ifid_valid = 1; ifid_rs1 = 7; ifid_rs1_used = 1; ifid_rd = 8; ifid_rd_we = 1;
    cycle("raw_stall0", 3'd2);
    cycle("raw_stall1", 3'd2);
    idex_mem_read = 1; idex_rd = 7;
    cycle("prio_load_use", 3'd1);
    idle(); ifid_valid = 1; ifid_rd = 7; ifid_rd_we = 1;
    cycle("waw", 3'd3);
    idle(); ll_op(UnitDiv, 5'd10);
    cycle("struct_div", 3'd4);
    idle(); ifid_valid = 1; ifid_rs1 = 7; ifid_rs1_used = 1; ifid_rd = 8; ifid_rd_we = 1;
    ll_done = 2'b01; ll_done_rd = {5'd0, 5'd7};
    cycle("raw_release", 3'd0);
    check("pend_after_done", sb_pending, 32'd0);
    check("stall_count_mid", {28'd0, stall_count}, exp_stall);

    // Issue to the divider in the same cycle it completes
    idle(); ll_op(UnitDiv, 5'd7);
    cycle("div_issue2", 3'd0);
    idle(); ll_op(UnitDiv, 5'd11); ll_done = 2'b01; ll_done_rd = {5'd0, 5'd7};
    cycle("div_issue_on_done", 3'd0);
    check("pend_reissue", sb_pending, 32'h800);
    idle(); ll_op(UnitDiv, 5'd12);
    cycle("struct_busy_kept", 3'd4);
    idle(); ll_done = 2'b01; ll_done_rd = {5'd0, 5'd11};
    cycle("done_idle", 3'd0);
    check("pend_cleared", sb_pending, 32'd0);

    // Same-edge set and clear of x9
    idle(); ll_op(UnitMul, 5'd9);
    cycle("mul_issue", 3'd0);
    check("pend_mul", sb_pending, 32'h200);
    idle(); ll_op(UnitMul, 5'd9); ll_done = 2'b10; ll_done_rd = {5'd9, 5'd0};
    cycle("mul_reissue_on_done", 3'd0);
    check("pend_set_wins", sb_pending, 32'h200);
    idle(); ifid_valid = 1; ifid_rs2 = 9; ifid_rs2_used = 1;
    cycle("raw_mul", 3'd2);
    idle(); ll_done = 2'b10; ll_done_rd = {5'd9, 5'd0};
    cycle("done_mul", 3'd0);
    check("pend_mul_clear", sb_pending, 32'd0);

    // Flush during a RAW stall
    idle(); ll_op(UnitDiv, 5'd7);
    cycle("div_issue3", 3'd0);
    idle(); ifid_valid = 1; ifid_rs1 = 7; ifid_rs1_used = 1;
    cycle("raw_pre_flush", 3'd2);
    flush = 1; ifid_ll_issue = 1; ifid_ll_unit = 1'(UnitMul); ifid_rd = 12; ifid_rd_we = 1;
    cycle("flush", 3'd0);
    check("pend_after_flush", sb_pending, 32'h80);
    idle(); ll_op(UnitMul, 5'd13);
    cycle("mul_after_flush", 3'd0);
    idle(); ll_op(UnitDiv, 5'd14); ll_done = 2'b01; ll_done_rd = {5'd0, 5'd20};
    cycle("div_issue_stray_done", 3'd0);
    check("pend_three", sb_pending, 32'h6080);
    check("stall_count_pre_reset", {28'd0, stall_count}, exp_stall);

    // Asynchronous reset in mid-cycle
    idle();
    #2 rst_n = 0;
    #1;
    exp_stall = 0;
    check("midreset_pending", sb_pending, 32'd0);
    check("midreset_stall_count", {28'd0, stall_count}, exp_stall);
    check("midreset_outputs", {25'd0, pc_write, ifid_write, idex_write, control_mux_sel,
          hazard_cause}, {25'd0, exp_outs(3'd0)});
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("post_reset_pending", sb_pending, 32'd0);

    // Stall counter saturation: 2^CntW + 5 stall cycles
    idle(); ifid_valid = 1; ifid_rs1 = 5; ifid_rs1_used = 1; idex_rd = 5; idex_mem_read = 1;
    for (int i = 0; i < (1 << CntW) + 5; i++) begin
      cycle("sat_stall", 3'd1);
      if (i == 12) check("stall_count_13", {28'd0, stall_count}, exp_stall);
    end
    check("stall_count_sat", {28'd0, stall_count}, 32'd15);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
